// File: rtl/bla_pkg.sv
// Shared definitions for the serial nibble subtractor: FSM states, nibble size
// and the nibble-count helper.
package bla_pkg;

   localparam int NIBBLE = 4;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   function automatic int nib_count(input int width);
      return width / NIBBLE;
   endfunction

endpackage

// File: rtl/bla4.sv
// 4-bit borrow-lookahead subtractor slice: d = x - y - bin, bout = borrow out of bit 3.
module bla4 (
   input  logic [3:0] x,
   input  logic [3:0] y,
   input  logic       bin,
   output logic [3:0] d,
   output logic       bout
);

   logic [3:0] g;
   logic [3:0] p;
   logic [4:0] br;

   assign g = ~x & y;
   assign p = ~(x ^ y);

   // Every borrow is expanded directly from g/p and bin, with no ripple between bits.
   assign br[0] = bin;
   assign br[1] = g[0] | (p[0] & bin);
   assign br[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bin);
   assign br[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & bin);
   assign br[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & bin);

   assign d    = x ^ y ^ br[3:0];
   assign bout = br[4];

endmodule

// File: rtl/bla_sub_serial.sv
// Serial subtractor: a - b - bin computed one nibble per cycle through a single
// bla4 slice, with valid/ready handshakes on both sides.
module bla_sub_serial
   import bla_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf,
   output logic             zero
);

   localparam int N   = nib_count(WIDTH);
   localparam int K_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [K_W-1:0] K_LAST = K_W'(N - 1);

   state_t           state_q, state_d;
   logic [K_W-1:0]   k_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic             br_q;
   logic [3:0]       nib_d;
   logic             nib_bout;
   logic [WIDTH-1:0] diff_next;
   logic             last_nib;

   assign last_nib = (k_q == K_LAST);

   bla4 u_bla4 (
      .x    (a_q[k_q*NIBBLE +: NIBBLE]),
      .y    (b_q[k_q*NIBBLE +: NIBBLE]),
      .bin  (br_q),
      .d    (nib_d),
      .bout (nib_bout)
   );

   always_comb begin
      diff_next = diff;
      diff_next[k_q*NIBBLE +: NIBBLE] = nib_d;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // NOTE: every output of this block gets a default first, so no path
   // through the case statement can infer a latch.
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = RUN;
         end
         RUN: begin
            if (last_nib) state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Results are only written in RUN, so they hold for as long as DONE is stalled.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         k_q  <= '0;
         a_q  <= '0;
         b_q  <= '0;
         br_q <= 1'b0;
         diff <= '0;
         bout <= 1'b0;
         ovf  <= 1'b0;
         zero <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid && in_ready) begin
                  a_q  <= a;
                  b_q  <= b;
                  br_q <= bin;
                  k_q  <= '0;
               end
            end
            RUN: begin
               diff <= diff_next;
               br_q <= nib_bout;
               k_q  <= last_nib ? '0 : k_q + 1'b1;
               if (last_nib) begin
                  bout <= nib_bout;
                  ovf  <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (diff_next[WIDTH-1] ^ a_q[WIDTH-1]);
                  zero <= (diff_next == '0);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bla_sub_serial.sv
// Self-checking bench for bla_sub_serial: directed vectors, backpressure,
// reset mid-operation and a random run against an arithmetic model.
module tb_bla_sub_serial;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a, b;
   logic         bin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] diff;
   logic         bout, ovf, zero;

   int n_checks = 0;
   int n_errors = 0;

   logic [W-1:0] got_diff;
   logic         got_bout, got_ovf, got_zero;

   bla_sub_serial #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .bout      (bout),
      .ovf       (ovf),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one operation, check latency and hold behaviour, capture results, then handshake.
   task automatic do_op(input logic [W-1:0] a_v, input logic [W-1:0] b_v, input logic bin_v,
                        input int in_stall, input int out_stall);
      int lat;
      for (int i = 0; i < in_stall; i++) tick();
      a = a_v; b = b_v; bin = bin_v; in_valid = 1'b1;
      tick();
      // Junk on the inputs while RUN must not disturb the latched operands.
      in_valid = 1'b1; a = ~a_v; b = a_v ^ 16'h5A5A; bin = ~bin_v;
      lat = 0;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      check("latency", 64'(lat), 64'd4);
      got_diff = diff; got_bout = bout; got_ovf = ovf; got_zero = zero;
      for (int i = 0; i < out_stall; i++) begin
         tick();
         check("hold_valid", 64'(out_valid), 64'd1);
         check("hold_in_ready", 64'(in_ready), 64'd0);
         check("hold_diff", 64'(diff), 64'(got_diff));
         check("hold_flags", {61'd0, bout, ovf, zero}, {61'd0, got_bout, got_ovf, got_zero});
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("post_hs_valid", 64'(out_valid), 64'd0);
      check("post_hs_in_ready", 64'(in_ready), 64'd1);
   endtask

   task automatic expect_res(input string tag, input logic [W-1:0] e_diff, input logic e_bout,
                             input logic e_ovf, input logic e_zero);
      check({tag, "_diff"}, 64'(got_diff), 64'(e_diff));
      check({tag, "_bout"}, 64'(got_bout), 64'(e_bout));
      check({tag, "_ovf"},  64'(got_ovf),  64'(e_ovf));
      check({tag, "_zero"}, 64'(got_zero), 64'(e_zero));
   endtask

   initial begin
      logic [W-1:0] ra, rb, m_diff;
      logic         rbin, m_bout, m_ovf;
      logic [W:0]   wide;
      int           sres;

      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b0;
      tick(); tick();
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_diff", 64'(diff), 64'd0);
      check("rst_flags", {61'd0, bout, ovf, zero}, 64'd0);
      rst_n = 1'b1;
      tick();
      check("rst_in_ready", 64'(in_ready), 64'd1);

      do_op(16'h1234, 16'h0234, 1'b0, 0, 0);
      expect_res("v1", 16'h1000, 1'b0, 1'b0, 1'b0);
      do_op(16'h0000, 16'h0001, 1'b0, 0, 0);
      expect_res("v2", 16'hFFFF, 1'b1, 1'b0, 1'b0);
      do_op(16'h8000, 16'h0001, 1'b0, 1, 0);
      expect_res("v3", 16'h7FFF, 1'b0, 1'b1, 1'b0);
      do_op(16'h0005, 16'h0004, 1'b1, 0, 0);
      expect_res("v4", 16'h0000, 1'b0, 1'b0, 1'b1);
      do_op(16'h1234, 16'h1234, 1'b1, 0, 0);
      expect_res("v5_full_borrow", 16'hFFFF, 1'b1, 1'b0, 1'b0);

      // Backpressure: three stalled DONE cycles.
      do_op(16'h7FFF, 16'hFFFF, 1'b0, 0, 3);
      expect_res("bp", 16'h8000, 1'b1, 1'b1, 1'b0);

      // Reset during the second RUN cycle.
      a = 16'h1234; b = 16'h0001; bin = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      rst_n = 1'b0;
      tick();
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_diff", 64'(diff), 64'd0);
      check("midrst_flags", {61'd0, bout, ovf, zero}, 64'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         check("midrst_no_result", 64'(out_valid), 64'd0);
      end
      do_op(16'h00FF, 16'h00FF, 1'b0, 0, 0);
      expect_res("after_rst", 16'h0000, 1'b0, 1'b0, 1'b1);

      // Random run against an arithmetic model.
      for (int n = 0; n < 1000; n++) begin
         ra = W'($urandom); rb = W'($urandom); rbin = 1'($urandom);
         if (n % 8 == 0) rb = ra;
         wide   = {1'b0, ra} - {1'b0, rb} - (W + 1)'(rbin);
         m_diff = wide[W-1:0];
         m_bout = wide[W];
         sres   = int'($signed(ra)) - int'($signed(rb)) - int'(rbin);
         m_ovf  = (sres > 32767) || (sres < -32768);
         do_op(ra, rb, rbin, $urandom_range(0, 2), $urandom_range(0, 2));
         expect_res("rand", m_diff, m_bout, m_ovf, (m_diff == '0));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/bla_sub_serial.md
BLA_SUB_SERIAL -- requirements
Module: bla_sub_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand width in bits; legal values are multiples of 4 from 4 to 64.
REQ-002 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: operands a, b and bin are valid.
REQ-005 SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-006 SHALL have port a, input, WIDTH bits: minuend, unsigned or two's complement.
REQ-007 SHALL have port b, input, WIDTH bits: subtrahend.
REQ-008 SHALL have port bin, input, 1 bit: borrow-in.
REQ-009 SHALL have port out_valid, output, 1 bit: result fields are valid.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-011 SHALL have port diff, output, WIDTH bits: a - b - bin, modulo 2^WIDTH.
REQ-012 SHALL have port bout, output, 1 bit: borrow-out; 1 iff a < b + bin, unsigned.
REQ-013 SHALL have port ovf, output, 1 bit: two's-complement overflow of the subtraction.
REQ-014 SHALL have port zero, output, 1 bit: 1 iff diff == 0.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-016 SHALL drive in_ready = 1 only in IDLE, and out_valid = 1 only in DONE.
REQ-017 SHALL accept operands in IDLE when in_valid & in_ready, latching a, b and bin and moving to RUN with nibble index k = 0.
REQ-018 SHALL process one 4-bit nibble per RUN cycle, starting at LSB nibble k = 0.
REQ-019 SHALL compute each nibble with borrow lookahead: g_i = ~a_i & b_i; p_i = ~(a_i ^ b_i); d_i = a_i ^ b_i ^ br_i; br_(i+1) = g_i | (p_i & br_i).
REQ-020 SHALL use the latched bin as the borrow into nibble 0, and the registered borrow-out of nibble k-1 as the borrow into nibble k.
REQ-021 SHALL write nibble k of diff in the cycle nibble k is processed.
REQ-022 SHALL enter DONE after nibble WIDTH/4-1; with acceptance at edge T, out_valid SHALL rise at edge T + WIDTH/4, a latency of WIDTH/4 cycles (4 for the default).
REQ-023 SHALL present, in DONE: bout = final nibble borrow-out; ovf = (a[MSB] ^ b[MSB]) & (diff[MSB] ^ a[MSB]); zero = (diff == 0).
REQ-024 SHALL hold diff, bout, ovf and zero stable while out_valid = 1 and out_ready = 0, for any number of cycles.
REQ-025 SHALL return to IDLE on out_valid & out_ready; no new operands SHALL be accepted in that same cycle, since in_ready is 0 in DONE.
REQ-026 SHALL ignore in_valid, a, b and bin outside IDLE; latched operands SHALL NOT change during RUN.
REQ-027 SHALL treat bin = 1 with a == b as a full-width borrow: diff = all ones, bout = 1.

Reset
REQ-028 SHALL, on clk edge with rst_n = 0, set state = IDLE, k = 0, diff = 0, bout = 0, ovf = 0, zero = 0, in_ready = 1 after release, out_valid = 0.
REQ-029 SHALL abandon any in-flight RUN or DONE operation on reset, with no result ever presented for it.

Structure
REQ-030 SHALL place the state enum (IDLE/RUN/DONE), the NIBBLE = 4 constant and the nibble-count helper in shared package bla_pkg.
REQ-031 SHALL instantiate exactly one combinational sub-module, bla4 (4-bit borrow-lookahead slice with ports x[4], y[4], bin, d[4], bout), reused every RUN cycle.

Verification
REQ-032 SHALL cover: a=0x1234, b=0x0234, bin=0 -> diff=0x1000, bout=0, ovf=0, zero=0, out_valid exactly 4 cycles after accept.
REQ-033 SHALL cover: a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, ovf=0.
REQ-034 SHALL cover: a=0x8000, b=0x0001, bin=0 -> diff=0x7FFF, bout=0, ovf=1; and a=0x0005, b=0x0004, bin=1 -> diff=0x0000, zero=1, bout=0.
REQ-035 SHALL cover backpressure: out_ready held 0 for 3 cycles in DONE -> outputs constant and in_ready=0 throughout; handshake -> IDLE next cycle.
REQ-036 SHALL cover reset mid-RUN: rst_n=0 at the 2nd RUN cycle -> next edge out_valid=0 and all outputs 0; after release, a fresh 0x00FF-0x00FF gives diff=0, zero=1.
REQ-037 SHALL cover a 1000-vector random run against a reference model of a - b - bin, with random in_valid/out_ready stalls.
